// File: rtl/m_7segarb.sv
// rtl/m_7segarb.sv - round-robin owner arbiter for the shared 7-segment display
//
// Purpose:
//   Shares one 8-digit 7-segment display between four requesters. One owner
//   at a time drives the display word. An owner keeps the display for at
//   least MINHOLD cycles so the value stays readable. Once it has held the
//   display for MAXHOLD cycles, any other pending requester preempts it.
//   Exactly one idle cycle separates consecutive owners.
//
// Ports:
//   w_clk   in   1    system clock, all state on rising edge
//   w_rst   in   1    asynchronous active-high reset
//   w_req   in   4    level-sensitive request, bit i = requester i
//   w_din   in   128  requester data, requester i at [32*i+31:32*i]
//   r_gnt   out  4    one-hot grant, 0 when no owner
//   r_idx   out  2    index of the current or most recent owner
//   r_busy  out  1    high while an owner holds the display
//   r_dout  out  32   display word, feeds m_7segcon w_din

module m_7segarb #(
  parameter int MINHOLD = 50000000,
  parameter int MAXHOLD = 250000000
) (
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic [3:0]   w_req,
  input  logic [127:0] w_din,
  output logic [3:0]   r_gnt,
  output logic [1:0]   r_idx,
  output logic         r_busy,
  output logic [31:0]  r_dout
);

  localparam logic [31:0] MIN_H = 32'(MINHOLD);
  localparam logic [31:0] MAX_H = 32'(MAXHOLD);

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state;
  logic [1:0]  r_last;
  logic [31:0] r_hcnt;

  logic [31:0] din_a [4];
  logic [1:0]  sel;
  logic [1:0]  cand;
  logic        found;
  logic        rel;
  logic        pre;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      assign din_a[g] = w_din[32*g +: 32];
    end
  endgenerate

  // Round-robin search starting just after the last owner; the k=4 step
  // wraps back to r_last itself so it is considered last.
  always_comb begin
    sel   = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = r_last + k[1:0];
      if (!found && w_req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Both exit tests look at the hold count before this edge's increment.
  assign rel = (r_hcnt >= MIN_H) && !w_req[r_idx];
  assign pre = (r_hcnt >= MAX_H) && (|(w_req & ~r_gnt));

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state  <= IDLE;
      r_gnt  <= 4'b0000;
      r_idx  <= 2'd3;
      r_last <= 2'd3;
      r_busy <= 1'b0;
      r_dout <= 32'd0;
      r_hcnt <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state  <= OWN;
            r_gnt  <= 4'b0001 << sel;
            r_idx  <= sel;
            r_last <= sel;
            r_busy <= 1'b1;
            r_hcnt <= 32'd1;
            r_dout <= din_a[sel];
          end else begin
            r_gnt  <= 4'b0000;
            r_busy <= 1'b0;
          end
        end
        OWN: begin
          if (rel || pre) begin
            // Display word and owner index are left as they were so the
            // screen does not flicker through the gap cycle.
            state  <= IDLE;
            r_gnt  <= 4'b0000;
            r_busy <= 1'b0;
            r_hcnt <= 32'd0;
          end else begin
            r_dout <= din_a[r_idx];
            if (r_hcnt < MAX_H) begin
              r_hcnt <= r_hcnt + 32'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_7segarb.sv
// tb/tb_m_7segarb.sv - scoreboard bench for m_7segarb
module tb_m_7segarb;

  logic         w_clk;
  logic         w_rst;
  logic [3:0]   w_req;
  logic [127:0] w_din;
  logic [3:0]   r_gnt;
  logic [1:0]   r_idx;
  logic         r_busy;
  logic [31:0]  r_dout;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [3:0]  gnt;
    logic        busy;
    logic [31:0] dout;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  m_7segarb #(.MINHOLD(4), .MAXHOLD(8)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_req (w_req),
    .w_din (w_din),
    .r_gnt (r_gnt),
    .r_idx (r_idx),
    .r_busy(r_busy),
    .r_dout(r_dout)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic set_din_default();
    for (int i = 0; i < 4; i++) w_din[32*i +: 32] = 32'd1111 * 32'(i + 1);
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    w_req = 4'b0000;
    set_din_default();
    @(negedge w_clk);
    w_rst = 1'b0;
  endtask

  function automatic exp_t mk(logic [3:0] gnt, logic [31:0] dout);
    exp_t x;
    x.gnt  = gnt;
    x.busy = (gnt != 4'b0000);
    x.dout = dout;
    return x;
  endfunction

  task automatic test_reset();
    @(negedge w_clk);
    n_tests++;
    if ({r_gnt, r_idx, r_busy, r_dout} !== {4'b0000, 2'd3, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_values got gnt=%b idx=%0d busy=%b dout=%0d exp gnt=0000 idx=3 busy=0 dout=0",
               r_gnt, r_idx, r_busy, r_dout);
    end
    w_rst = 1'b0;
    w_req = 4'b0100;
    @(negedge w_clk);
    n_tests++;
    if ({r_gnt, r_idx, r_busy, r_dout} !== {4'b0100, 2'd2, 1'b1, 32'd3333}) begin
      n_fail++;
      $display("FAIL reset_pre_own got gnt=%b idx=%0d busy=%b dout=%0d exp gnt=0100 idx=2 busy=1 dout=3333",
               r_gnt, r_idx, r_busy, r_dout);
    end
    #2 w_rst = 1'b1;
    #1;
    n_tests++;
    if ({r_gnt, r_idx, r_busy, r_dout} !== {4'b0000, 2'd3, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_async got gnt=%b idx=%0d busy=%b dout=%0d exp gnt=0000 idx=3 busy=0 dout=0",
               r_gnt, r_idx, r_busy, r_dout);
    end
    w_req = 4'b0101;
    @(negedge w_clk);
    w_rst = 1'b0;
    @(negedge w_clk);
    n_tests++;
    if ({r_gnt, r_idx, r_busy, r_dout} !== {4'b0001, 2'd0, 1'b1, 32'd1111}) begin
      n_fail++;
      $display("FAIL reset_restart got gnt=%b idx=%0d busy=%b dout=%0d exp gnt=0001 idx=0 busy=1 dout=1111",
               r_gnt, r_idx, r_busy, r_dout);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      w_req = (c == 0) ? 4'b0001 : 4'b0000;
      sb.push_back(mk((c < 4) ? 4'b0001 : 4'b0000, 32'd1111));
      @(negedge w_clk);
      e = sb.pop_front();
      n_tests++;
      if ({r_gnt, r_busy, r_dout} !== {e.gnt, e.busy, e.dout}) begin
        n_fail++;
        $display("FAIL basic c=%0d got gnt=%b busy=%b dout=%0d exp gnt=%b busy=%b dout=%0d",
                 c, r_gnt, r_busy, r_dout, e.gnt, e.busy, e.dout);
      end
    end
  endtask

  task automatic test_round_robin();
    int seg;
    int pos;
    int own;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      seg = c / 5;
      pos = c % 5;
      own = seg % 4;
      w_req = (pos == 4) ? (4'b1111 & ~(4'b0001 << own)) : 4'b1111;
      sb.push_back(mk((pos == 4) ? 4'b0000 : (4'b0001 << own), 32'd1111 * 32'(own + 1)));
      @(negedge w_clk);
      e = sb.pop_front();
      n_tests++;
      if ({r_gnt, r_busy, r_dout} !== {e.gnt, e.busy, e.dout}) begin
        n_fail++;
        $display("FAIL round_robin c=%0d got gnt=%b busy=%b dout=%0d exp gnt=%b busy=%b dout=%0d",
                 c, r_gnt, r_busy, r_dout, e.gnt, e.busy, e.dout);
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      w_req = (c >= 2 && c <= 12) ? 4'b1010 : 4'b0010;
      if (c <= 7)       sb.push_back(mk(4'b0010, 32'd2222));
      else if (c == 8)  sb.push_back(mk(4'b0000, 32'd2222));
      else if (c <= 12) sb.push_back(mk(4'b1000, 32'd4444));
      else if (c == 13) sb.push_back(mk(4'b0000, 32'd4444));
      else              sb.push_back(mk(4'b0010, 32'd2222));
      @(negedge w_clk);
      e = sb.pop_front();
      n_tests++;
      if ({r_gnt, r_busy, r_dout} !== {e.gnt, e.busy, e.dout}) begin
        n_fail++;
        $display("FAIL preempt c=%0d got gnt=%b busy=%b dout=%0d exp gnt=%b busy=%b dout=%0d",
                 c, r_gnt, r_busy, r_dout, e.gnt, e.busy, e.dout);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_h;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      w_req = 4'b0100;
      sb.push_back(mk(4'b0100, 32'd3333));
      exp_h = (c + 1 < 8) ? 32'(c + 1) : 32'd8;
      @(negedge w_clk);
      e = sb.pop_front();
      n_tests++;
      if ({r_gnt, r_busy, r_dout, dut.r_hcnt} !== {e.gnt, e.busy, e.dout, exp_h}) begin
        n_fail++;
        $display("FAIL saturation c=%0d got gnt=%b busy=%b dout=%0d hcnt=%0d exp gnt=%b busy=%b dout=%0d hcnt=%0d",
                 c, r_gnt, r_busy, r_dout, dut.r_hcnt, e.gnt, e.busy, e.dout, exp_h);
      end
    end
  endtask

  task automatic test_live_data();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      w_req = 4'b0001;
      if (c == 2) w_din[31:0] = 32'd42;
      if (c == 4) w_din[95:64] = 32'd99;
      sb.push_back(mk(4'b0001, (c < 2) ? 32'd1111 : 32'd42));
      @(negedge w_clk);
      e = sb.pop_front();
      n_tests++;
      if ({r_gnt, r_busy, r_dout} !== {e.gnt, e.busy, e.dout}) begin
        n_fail++;
        $display("FAIL live_data c=%0d got gnt=%b busy=%b dout=%0d exp gnt=%b busy=%b dout=%0d",
                 c, r_gnt, r_busy, r_dout, e.gnt, e.busy, e.dout);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    w_rst   = 1'b1;
    w_req   = 4'b0000;
    w_din   = '0;
    set_din_default();
    test_reset();
    test_basic();
    test_round_robin();
    test_preempt();
    test_saturation();
    test_live_data();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_7segarb.md
Name: m_7segarb

Overview:
- Round-robin arbiter and scheduler that shares the single 8-digit 7-segment display between four requesters.
- Each requester presents a 32-bit value and a request line. The block grants one owner at a time and forwards the owner's value as the display word for m_7segcon.
- Enforces a minimum on-screen hold time so values stay readable, and a maximum hold time after which a waiting requester preempts the owner.

Parameters:
- MINHOLD, 50000000: minimum cycles an owner keeps the display (1 s at 50 MHz); must be >= 1.
- MAXHOLD, 250000000: cycles after which the owner is preempted if another request is pending; must be >= MINHOLD.

Ports:
- w_clk  input  1  system clock, all state on rising edge.
- w_rst  input  1  asynchronous active-high reset.
- w_req  input  4  request, bit i = requester i; level-sensitive.
- w_din  input  128  requester data; requester i at bits [32*i+31:32*i].
- r_gnt  output  4  one-hot grant, or 4'b0000 when no owner.
- r_idx  output  2  index of the current or most recent owner.
- r_busy  output  1  1 while an owner holds the display (state OWN).
- r_dout  output  32  display word, connects to m_7segcon w_din.

Behaviour:
- Interface: one clock w_clk. w_rst is asynchronous and active-high, and clears all state immediately regardless of w_clk.
- Reset values:
  - r_gnt=0, r_idx=3, r_busy=0, r_dout=0.
  - Internal state=IDLE, r_last=3, r_hcnt=0.
- States: IDLE, OWN.
- Round-robin selection: search w_req starting at (r_last+1) mod 4, ascending and wrapping. The first set bit wins. After reset requester 0 has top priority.
- IDLE:
  - If w_req==0: stay in IDLE. r_gnt=0, r_busy=0, r_dout holds its last value.
  - If any request is set, at the next edge:
    - state=OWN, r_gnt=onehot(sel), r_idx=sel, r_last=sel, r_busy=1.
    - r_hcnt=1, r_dout=w_din[sel].
  - Latency from a request sampled to grant and data visible is 1 cycle.
- OWN, every edge:
  - r_dout <= w_din[r_idx], so the owner may update its value live with 1-cycle latency.
  - r_hcnt <= r_hcnt+1, saturating at MAXHOLD. r_hcnt is 32 bits wide.
- OWN exit, evaluated on registered r_hcnt before the increment; exit if either condition holds:
  - (a) release: r_hcnt >= MINHOLD and w_req[r_idx]==0.
  - (b) preempt: r_hcnt >= MAXHOLD and (w_req & ~r_gnt) != 0.
- On exit, at the next edge:
  - state=IDLE, r_gnt=0, r_busy=0.
  - r_dout and r_idx hold; r_hcnt=0.
- Gap cycle: exactly one IDLE cycle separates consecutive owners. A new owner is therefore granted 2 edges after the exit condition is seen.
- Early release: if the owner deasserts its request before MINHOLD, the grant is kept until r_hcnt reaches MINHOLD, then it exits. The display stays stable during this time.
- Preempted owner: its request may stay high. Round-robin places it last, so it regains the display only after the other pending requesters have been served.
- Single requester with its request held permanently: it is never preempted, because condition (b) requires another request. r_hcnt stays saturated at MAXHOLD.
- Simultaneous release and preempt in one cycle: both lead to the same exit, so the behaviour is identical.
- Requests changing during the IDLE gap: selection uses w_req as sampled at the granting edge.
- Reset mid-OWN: the grant drops and r_dout=0 immediately (asynchronous). After reset is removed, the next arbitration starts from requester 0.
- r_gnt always has at most one bit set. r_gnt!=0 if and only if r_busy==1.

Test Plan:
Bench uses MINHOLD=4, MAXHOLD=8, and w_din[i] = 32'd1111*(i+1).
1. Reset mid-operation: assert w_rst while requester 2 owns -> r_gnt=0, r_dout=0 without a clock edge. After release, w_req=4'b0101 -> requester 0 granted first.
2. Basic grant and release:
   - w_req=4'b0001 from cycle 0 -> r_gnt=0001, r_dout=1111 after edge 1.
   - Drop the request at edge 2 -> grant persists until r_hcnt reaches 4, then r_gnt=0 for one cycle, r_dout stays 1111.
3. Round-robin:
   - w_req=4'b1111 held, each owner dropping its request once r_hcnt>=4 -> grant order 0,1,2,3,0.
   - Each owner gets exactly 4 cycles with 1 idle cycle between owners.
   - r_dout follows 1111, 2222, 3333, 4444.
4. Preemption:
   - Requester 1 holds its request continuously; requester 3 raises its request at cycle 2 -> requester 1 keeps the grant until r_hcnt=8.
   - Then one gap cycle, then r_gnt=1000, r_dout=4444.
   - Requester 1 is regranted only after requester 3 releases.
5. Sole-owner saturation: only requester 2 requests, for 20 cycles -> r_gnt=0100 throughout, r_hcnt saturates at 8, no gap cycles.
6. Live data update: while requester 0 owns, change w_din[31:0] to 42 -> r_dout=42 one cycle later. Changes on non-owner data lanes do not alter r_dout.
